// File: rtl/seq_counter_ctrl_if.sv
// Control/status bundle for the sequence-counter run controller.
// The master side drives run requests and configuration; the slave side returns the code and strobes.
interface seq_counter_ctrl_if #(
  parameter int PRESCALE_W = 8,
  parameter int CYCLES_W   = 4
);
  logic                  start;
  logic                  stop;
  logic                  dir;
  logic [PRESCALE_W-1:0] div;
  logic [CYCLES_W-1:0]   n_cycles;
  logic [3:0]            code;
  logic                  step;
  logic                  wrap;
  logic                  busy;
  logic                  done;
  logic [CYCLES_W-1:0]   pass_cnt;

  modport master (
    output start, stop, dir, div, n_cycles,
    input  code, step, wrap, busy, done, pass_cnt
  );

  modport slave (
    input  start, stop, dir, div, n_cycles,
    output code, step, wrap, busy, done, pass_cnt
  );
endinterface

// File: rtl/seq_counter_ctrl.sv
// Run controller for the eight-code sequence ring: prescaled stepping, forward or reverse,
// counted passes or free-run, with registered code and step/wrap/done strobes.
module seq_counter_ctrl #(
  parameter int PRESCALE_W = 8,
  parameter int CYCLES_W   = 4
) (
  input logic CLK,
  input logic CLR,
  seq_counter_ctrl_if.slave bus
);

  typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;

  state_t                state_reg, state_next;
  logic [3:0]            code_reg, code_next;
  logic                  step_reg, step_next;
  logic                  wrap_reg, wrap_next;
  logic                  done_reg, done_next;
  logic [CYCLES_W-1:0]   pass_cnt_reg, pass_cnt_next;
  logic [PRESCALE_W-1:0] prescale_reg, prescale_next;
  logic                  dir_reg, dir_next;
  logic [PRESCALE_W-1:0] div_reg, div_next;
  logic [CYCLES_W-1:0]   n_cycles_reg, n_cycles_next;

  logic [3:0]            ring_next;
  logic [CYCLES_W-1:0]   pass_inc;

  // Ring successor in either direction; an illegal code recovers to 0000.
  function automatic logic [3:0] ring_step(input logic [3:0] cur, input logic rev);
    logic [3:0] nxt;
    nxt = 4'h0;
    if (!rev) begin
      case (cur)
        4'h0: nxt = 4'h5;
        4'h5: nxt = 4'hA;
        4'hA: nxt = 4'h6;
        4'h6: nxt = 4'h9;
        4'h9: nxt = 4'h3;
        4'h3: nxt = 4'hC;
        4'hC: nxt = 4'hF;
        default: nxt = 4'h0;
      endcase
    end else begin
      case (cur)
        4'h0: nxt = 4'hF;
        4'hF: nxt = 4'hC;
        4'hC: nxt = 4'h3;
        4'h3: nxt = 4'h9;
        4'h9: nxt = 4'h6;
        4'h6: nxt = 4'hA;
        4'hA: nxt = 4'h5;
        default: nxt = 4'h0;
      endcase
    end
    return nxt;
  endfunction

  assign ring_next = ring_step(code_reg, dir_reg);
  assign pass_inc  = pass_cnt_reg + 1'b1;

  always_ff @(posedge CLK or negedge CLR) begin
    if (!CLR) begin
      state_reg    <= IDLE;
      code_reg     <= 4'h0;
      step_reg     <= 1'b0;
      wrap_reg     <= 1'b0;
      done_reg     <= 1'b0;
      pass_cnt_reg <= '0;
      prescale_reg <= '0;
      dir_reg      <= 1'b0;
      div_reg      <= '0;
      n_cycles_reg <= '0;
    end else begin
      state_reg    <= state_next;
      code_reg     <= code_next;
      step_reg     <= step_next;
      wrap_reg     <= wrap_next;
      done_reg     <= done_next;
      pass_cnt_reg <= pass_cnt_next;
      prescale_reg <= prescale_next;
      dir_reg      <= dir_next;
      div_reg      <= div_next;
      n_cycles_reg <= n_cycles_next;
    end
  end

  always_comb begin
    state_next    = state_reg;
    code_next     = code_reg;
    step_next     = 1'b0;
    wrap_next     = 1'b0;
    done_next     = 1'b0;
    pass_cnt_next = pass_cnt_reg;
    prescale_next = prescale_reg;
    dir_next      = dir_reg;
    div_next      = div_reg;
    n_cycles_next = n_cycles_reg;

    case (state_reg)
      IDLE: begin
        if (bus.start && !bus.stop) begin
          state_next    = RUN;
          dir_next      = bus.dir;
          div_next      = bus.div;
          n_cycles_next = bus.n_cycles;
          code_next     = 4'h0;
          prescale_next = '0;
          pass_cnt_next = '0;
        end
      end
      RUN: begin
        // Stop beats a due step: code, pass count and strobes stay quiet.
        if (bus.stop) begin
          state_next = IDLE;
        end else if (prescale_reg == div_reg) begin
          prescale_next = '0;
          code_next     = ring_next;
          step_next     = 1'b1;
          if (ring_next == 4'h0) begin
            wrap_next     = 1'b1;
            pass_cnt_next = pass_inc;
            if ((n_cycles_reg != '0) && (pass_inc == n_cycles_reg)) begin
              state_next = IDLE;
              done_next  = 1'b1;
            end
          end
        end else begin
          prescale_next = prescale_reg + 1'b1;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  assign bus.code     = code_reg;
  assign bus.step     = step_reg;
  assign bus.wrap     = wrap_reg;
  assign bus.done     = done_reg;
  assign bus.busy     = (state_reg == RUN);
  assign bus.pass_cnt = pass_cnt_reg;

endmodule

// File: tb/tb_seq_counter_ctrl.sv
// Directed bench for seq_counter_ctrl: ring order both ways, prescaling, pass counting,
// stop priority, config latching, free-run wrap and asynchronous reset.
module tb_seq_counter_ctrl;
  localparam int PRESCALE_W = 8;
  localparam int CYCLES_W   = 4;

  logic CLK;
  logic CLR;
  int   vectors;
  int   miscompares;

  seq_counter_ctrl_if #(.PRESCALE_W(PRESCALE_W), .CYCLES_W(CYCLES_W)) bus ();

  seq_counter_ctrl #(.PRESCALE_W(PRESCALE_W), .CYCLES_W(CYCLES_W)) dut (
    .CLK (CLK),
    .CLR (CLR),
    .bus (bus.slave)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  logic [3:0] fwd_tab [8];
  logic [3:0] rev_tab [8];

  task automatic chk(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    vectors++;
    assert (observed === expected)
    else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  // Code register must always hold one of the eight ring codes.
  always @(negedge CLK) begin
    if (CLR === 1'b1) begin
      case (bus.code)
        4'h0, 4'h5, 4'hA, 4'h6, 4'h9, 4'h3, 4'hC, 4'hF: ;
        default: begin
          miscompares++;
          $error("FAIL legal_code observed=%0h expected=ring_member", bus.code);
        end
      endcase
    end
  end

  initial begin
    int steps;
    int wraps;
    vectors     = 0;
    miscompares = 0;
    fwd_tab = '{4'h5, 4'hA, 4'h6, 4'h9, 4'h3, 4'hC, 4'hF, 4'h0};
    rev_tab = '{4'hF, 4'hC, 4'h3, 4'h9, 4'h6, 4'hA, 4'h5, 4'h0};

    CLR = 1'b0;
    bus.start = 0; bus.stop = 0; bus.dir = 0; bus.div = '0; bus.n_cycles = '0;
    tick(); tick();
    chk("rst_code", 32'(bus.code), 0);
    chk("rst_busy", 32'(bus.busy), 0);
    chk("rst_pass", 32'(bus.pass_cnt), 0);
    chk("rst_strobes", {29'd0, bus.step, bus.wrap, bus.done}, 0);
    CLR = 1'b1;
    tick();
    chk("idle_busy", 32'(bus.busy), 0);

    // Single forward pass, div=0
    bus.div = 8'd0; bus.dir = 0; bus.n_cycles = 4'd1; bus.start = 1;
    tick();
    bus.start = 0;
    chk("fwd_start_busy", 32'(bus.busy), 1);
    chk("fwd_start_code", 32'(bus.code), 0);
    for (int i = 0; i < 8; i++) begin
      tick();
      chk($sformatf("fwd_code%0d", i), 32'(bus.code), 32'(fwd_tab[i]));
      chk($sformatf("fwd_step%0d", i), 32'(bus.step), 1);
      chk($sformatf("fwd_wrap%0d", i), 32'(bus.wrap), (i == 7) ? 1 : 0);
      chk($sformatf("fwd_done%0d", i), 32'(bus.done), (i == 7) ? 1 : 0);
      chk($sformatf("fwd_busy%0d", i), 32'(bus.busy), (i == 7) ? 0 : 1);
    end
    chk("fwd_pass", 32'(bus.pass_cnt), 1);
    tick();
    chk("fwd_after_code", 32'(bus.code), 0);
    chk("fwd_after_strobes", {29'd0, bus.step, bus.wrap, bus.done}, 0);
    chk("fwd_after_pass", 32'(bus.pass_cnt), 1);

    // Reverse, div=2, two passes
    bus.div = 8'd2; bus.dir = 1; bus.n_cycles = 4'd2; bus.start = 1;
    tick();
    bus.start = 0;
    steps = 0;
    for (int t = 1; t <= 48; t++) begin
      tick();
      if (bus.step === 1'b1) steps++;
      chk($sformatf("rev_step_t%0d", t), 32'(bus.step), (t % 3 == 0) ? 1 : 0);
      if (t % 3 == 0)
        chk($sformatf("rev_code_t%0d", t), 32'(bus.code), 32'(rev_tab[(t / 3 - 1) % 8]));
      chk($sformatf("rev_wrap_t%0d", t), 32'(bus.wrap), (t == 24 || t == 48) ? 1 : 0);
      chk($sformatf("rev_done_t%0d", t), 32'(bus.done), (t == 48) ? 1 : 0);
      chk($sformatf("rev_busy_t%0d", t), 32'(bus.busy), (t == 48) ? 0 : 1);
    end
    chk("rev_step_total", 32'(steps), 16);
    chk("rev_pass", 32'(bus.pass_cnt), 2);

    // Stop collides with a due step at code 0110
    bus.div = 8'd1; bus.dir = 0; bus.n_cycles = 4'd0; bus.start = 1;
    tick();
    bus.start = 0;
    for (int i = 0; i < 6; i++) tick();
    chk("coll_pre_code", 32'(bus.code), 32'h6);
    chk("coll_pre_step", 32'(bus.step), 1);
    tick();
    chk("coll_gap_step", 32'(bus.step), 0);
    bus.stop = 1;
    tick();
    bus.stop = 0;
    chk("coll_code", 32'(bus.code), 32'h6);
    chk("coll_step", 32'(bus.step), 0);
    chk("coll_done", 32'(bus.done), 0);
    chk("coll_busy", 32'(bus.busy), 0);

    // start+stop together in IDLE: stop wins
    bus.start = 1; bus.stop = 1;
    tick();
    bus.start = 0; bus.stop = 0;
    chk("prio_busy", 32'(bus.busy), 0);
    chk("prio_code", 32'(bus.code), 32'h6);

    // Free run at div=0, with config changes and start pulses during RUN
    bus.div = 8'd0; bus.n_cycles = 4'd0; bus.dir = 0; bus.start = 1;
    tick();
    bus.start = 0;
    bus.div = 8'd5;
    bus.n_cycles = 4'd1;
    bus.dir = 1;
    tick();
    chk("latch_code1", 32'(bus.code), 32'h5);
    chk("latch_step1", 32'(bus.step), 1);
    tick();
    chk("latch_code2", 32'(bus.code), 32'hA);
    chk("latch_step2", 32'(bus.step), 1);
    bus.start = 1;
    tick();
    bus.start = 0;
    chk("rerun_code", 32'(bus.code), 32'h6);
    chk("rerun_step", 32'(bus.step), 1);
    chk("rerun_pass", 32'(bus.pass_cnt), 0);
    wraps = 0;
    for (int s = 4; s <= 128; s++) begin
      tick();
      if (bus.wrap === 1'b1) wraps++;
      chk($sformatf("free_step_s%0d", s), 32'(bus.step), 1);
      chk($sformatf("free_code_s%0d", s), 32'(bus.code), 32'(fwd_tab[(s - 1) % 8]));
      chk($sformatf("free_busy_s%0d", s), 32'(bus.busy), 1);
      chk($sformatf("free_done_s%0d", s), 32'(bus.done), 0);
    end
    chk("free_wraps", 32'(wraps), 16);
    chk("free_pass", 32'(bus.pass_cnt), 0);
    bus.stop = 1;
    tick();
    bus.stop = 0;
    chk("free_stop_busy", 32'(bus.busy), 0);

    // Reset mid-run after five steps at div=3
    bus.div = 8'd3; bus.dir = 0; bus.n_cycles = 4'd0; bus.start = 1;
    tick();
    bus.start = 0;
    for (int i = 0; i < 20; i++) tick();
    chk("mid_code", 32'(bus.code), 32'h3);
    chk("mid_busy", 32'(bus.busy), 1);
    #2;
    CLR = 1'b0;
    #1;
    chk("arst_code", 32'(bus.code), 0);
    chk("arst_busy", 32'(bus.busy), 0);
    chk("arst_pass", 32'(bus.pass_cnt), 0);
    tick();
    CLR = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk($sformatf("post_rst_done%0d", i), 32'(bus.done), 0);
      chk($sformatf("post_rst_busy%0d", i), 32'(bus.busy), 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/seq_counter_ctrl.md
Name: seq_counter_ctrl

Overview:
Run controller for the 4-bit eight-code sequence counter. It sequences the fixed code ring 0000 -> 0101 -> 1010 -> 0110 -> 1001 -> 0011 -> 1100 -> 1111 -> 0000, forward or reverse. Each step is paced by a programmable prescaler. A run lasts a programmed number of full passes, or runs until stopped. It drives the code word and step/wrap/done strobes to downstream logic, with a start/stop control interface.

Parameters:
PRESCALE_W, 8, width of step divider; one step every div+1 clocks
CYCLES_W, 4, width of pass-count request and pass counter

Ports:
CLK  in  1  clock, rising edge
CLR  in  1  asynchronous active-low reset
start  in  1  level, sampled in IDLE; begins a run
stop  in  1  level, sampled every cycle; aborts a run
dir  in  1  0 = forward ring order, 1 = reverse; latched at start
div  in  PRESCALE_W  step period minus one; latched at start
n_cycles  in  CYCLES_W  full passes per run, 0 = run until stop; latched at start
code  out  4  current sequence code, registered
step  out  1  one-cycle pulse, high in the cycle code holds a newly stepped value
wrap  out  1  one-cycle pulse, high when a step lands on 0000
busy  out  1  high while in RUN
done  out  1  one-cycle pulse on natural completion (not on stop)
pass_cnt  out  CYCLES_W  completed passes in the current/last run, registered

Behaviour:
- Reset (CLR low, async):
  - state=IDLE; code=0000; step=wrap=done=busy=0; pass_cnt=0; prescaler=0; latched config cleared to 0.
  - Takes effect immediately, including mid-run. No done is issued.
  - Release is synchronous to the next CLK edge.
- All outputs are registered. No combinational input-to-output paths.
- FSM states: IDLE, RUN.
- IDLE:
  - busy=0; code holds its last value.
  - start=1 and stop=0 at edge k -> RUN after edge k.
    - Latch dir/div/n_cycles; code=0000; prescaler=0; pass_cnt=0; busy=1.
  - start=1 and stop=1 -> stay IDLE; stop wins.
- RUN:
  - Prescaler increments each cycle.
  - When prescaler==div_latched: prescaler->0 and code advances one ring position (reverse order if dir_latched=1); step=1 after that edge.
  - First step occurs div+1 edges after the start edge. With div=0, code changes every cycle.
  - A step landing on 0000 sets wrap=1 and pass_cnt+1 (modulo 2^CYCLES_W).
  - If n_cycles_latched!=0 and the incremented pass_cnt equals n_cycles_latched: state->IDLE on that same edge.
    - code=0000, wrap=1, step=1, done=1, busy=0, all together for one cycle.
  - n_cycles_latched=0: runs indefinitely. pass_cnt wraps freely and never triggers done.
  - stop=1 at any RUN edge -> IDLE, busy=0, done=0.
    - If stop coincides with a due step, stop wins: no step, no wrap, code holds the pre-step value.
    - pass_cnt holds.
  - start while in RUN is ignored. dir/div/n_cycles changes during RUN are ignored.
- Reverse order: 0000 -> 1111 -> 1100 -> 0011 -> 1001 -> 0110 -> 1010 -> 0101 -> 0000. wrap applies identically.
- step/wrap/done are never asserted in IDLE except the single completion cycle described above.
- The code register only ever holds one of the eight legal codes. Any other value is a design bug; a bench assertion checks this every cycle.

Test Plan:
- Reset mid-run:
  - Stimulus: run with div=3, n_cycles=0; assert CLR low between edges after 5 steps.
  - Required: code=0000, busy=0, pass_cnt=0 immediately, before the next edge. No done after release.
- Single forward pass:
  - Stimulus: div=0, dir=0, n_cycles=1, start pulse at edge k.
  - Required: code 0101,1010,0110,1001,0011,1100,1111,0000 after edges k+1..k+8. step high k+1..k+8. Cycle after k+8: wrap=done=1 and busy=0; pass_cnt=1. code holds 0000 thereafter.
- Reverse with prescale:
  - Stimulus: div=2, dir=1, n_cycles=2.
  - Required: first code 1111 after edge k+3; steps every 3 cycles; wrap after edges k+24 and k+48. done with the second wrap; 16 step pulses total.
- Stop/step collision:
  - Stimulus: div=1, n_cycles=0; raise stop on the edge a step is due, with code=0110.
  - Required: code stays 0110, step=0, done=0, busy=0 next cycle.
- Start/stop priority and config latching:
  - Stimulus: in IDLE, start=stop=1 -> stays IDLE. Then start alone with div=0, change div to 5 during RUN.
  - Required: step cadence remains every cycle. Start pulses during RUN do not reset code or pass_cnt.
- Free-run pass wrap:
  - Stimulus: n_cycles=0, div=0, CYCLES_W=4, run 16 passes (128 steps).
  - Required: 16 wrap pulses; pass_cnt returns to 0; done never asserted; busy stays 1.
